// File: rtl/binary_to_bcd_seq_pkg.sv
// Shared definitions for the sequential double-dabble converter:
// FSM encoding, BCD digit width and elaboration-time sizing helpers.
package binary_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // True when DIGITS decimal digits can represent every WIDTH-bit magnitude.
    function automatic bit digits_fit(input int width, input int digits);
        longint p10;
        longint p2;
        if (width >= 62) return 1'b0;
        p10 = 1;
        for (int i = 0; i < digits; i++) begin
            if (p10 > (longint'(1) << 62) / 10) return 1'b1;
            p10 = p10 * 10;
        end
        p2 = longint'(1) << width;
        return p10 > p2;
    endfunction

endpackage

// File: rtl/binary_to_bcd_seq_add3.sv
// One double-dabble correction stage: a BCD digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
import binary_to_bcd_seq_pkg::*;

module binary_to_bcd_seq_add3 (
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes, optional signed input and leading-zero flags.
import binary_to_bcd_seq_pkg::*;

module binary_to_bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] out_bcd,
    output logic                    out_sign,
    output logic [DIGITS-1:0]       out_blank
);

    localparam int CNT_W = clog2(WIDTH + 1);
    localparam int BCD_TOT = BCD_W * DIGITS;

    if (WIDTH < 4) begin : g_bad_width
        $error("binary_to_bcd_seq: WIDTH must be at least 4");
    end
    if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_digits
        $error("binary_to_bcd_seq: DIGITS too small for WIDTH");
    end

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     bin_reg;
    logic [BCD_TOT-1:0]   bcd_reg;
    logic                 sign_reg;
    logic [BCD_TOT-1:0]   res_bcd;
    logic                 res_sign;

    logic                 neg;
    logic [WIDTH-1:0]     mag;
    logic [BCD_TOT-1:0]   bcd_corr;
    logic [BCD_TOT-1:0]   bcd_shift;
    logic                 accept;
    logic                 last_shift;

    assign neg    = (SIGNED != 0) && in_data[WIDTH-1];
    assign mag    = neg ? (~in_data + WIDTH'(1)) : in_data;
    assign accept = in_valid & in_ready;
    assign last_shift = (state == ST_SHIFT) && (cnt == CNT_W'(1));

    // One correction stage per digit, reused on every shift cycle.
    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        binary_to_bcd_seq_add3 u_add3 (
            .din  (bcd_reg[BCD_W*d +: BCD_W]),
            .dout (bcd_corr[BCD_W*d +: BCD_W])
        );
    end

    assign bcd_shift = {bcd_corr[BCD_TOT-2:0], bin_reg[WIDTH-1]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(1)) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = in_valid ? ST_SHIFT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Working registers shift every SHIFT cycle; the visible result is only
    // updated on the final shift so intermediate values never reach the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            bin_reg  <= '0;
            bcd_reg  <= '0;
            sign_reg <= 1'b0;
            res_bcd  <= '0;
            res_sign <= 1'b0;
        end else if (accept) begin
            cnt      <= CNT_W'(WIDTH);
            bin_reg  <= mag;
            bcd_reg  <= '0;
            sign_reg <= neg;
        end else if (state == ST_SHIFT) begin
            cnt     <= cnt - CNT_W'(1);
            bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
            bcd_reg <= bcd_shift;
            if (last_shift) begin
                res_bcd  <= bcd_shift;
                res_sign <= sign_reg;
            end
        end
    end

    assign out_bcd  = res_bcd;
    assign out_sign = res_sign;

    // Leading-zero flags: digit k is blank when it and all higher digits are zero.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        out_blank = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero     = all_zero & (res_bcd[BCD_W*k +: BCD_W] == '0);
            out_blank[k] = all_zero;
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed and swept checks of binary_to_bcd_seq: unsigned 14-bit/5-digit
// instance plus a signed 8-bit/3-digit instance.
module tb_binary_to_bcd_seq;

    logic        clk;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic        out_sign;
    logic [4:0]  out_blank;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [11:0] s_out_bcd;
    logic        s_out_sign;
    logic [2:0]  s_out_blank;

    int checks;
    int failures;

    binary_to_bcd_seq #(.WIDTH(14), .DIGITS(5), .SIGNED(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_sign  (out_sign),
        .out_blank (out_blank)
    );

    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_bcd   (s_out_bcd),
        .out_sign  (s_out_sign),
        .out_blank (s_out_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] model_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_blank(input logic [19:0] b);
        logic [4:0] r;
        r = '0;
        for (int k = 1; k < 5; k++) r[k] = ((b >> (4*k)) == 20'd0);
        return r;
    endfunction

    // Present a value and return #1 after the edge that accepted it.
    task automatic send(input logic [13:0] v);
        int n;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges from now until out_valid is seen; -1 on timeout.
    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!out_valid) edges = -1;
    endtask

    task automatic s_convert(input logic [7:0] v, output int edges);
        s_in_valid = 1'b1;
        s_in_data  = v;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        edges = 0;
        while (!s_out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!s_out_valid) edges = -1;
    endtask

    task automatic test_reset;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_bcd !== 20'h0 || out_sign !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: bcd=%h sign=%b want 00000/0", out_bcd, out_sign);
        end
        checks++;
        if (out_blank !== 5'b11110 || s_out_blank !== 3'b110) begin
            failures++;
            $display("FAIL reset_blank: blank=%b s_blank=%b want 11110/110", out_blank, s_out_blank);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_latency_9999;
        int e;
        out_ready = 1'b0;
        send(14'd9999);
        wait_out(e);
        checks++;
        if (e !== 14) begin
            failures++;
            $display("FAIL latency_9999: edges=%0d want 14", e);
        end
        checks++;
        if (out_bcd !== 20'h09999 || out_blank !== 5'b10000) begin
            failures++;
            $display("FAIL value_9999: bcd=%h blank=%b want 09999/10000", out_bcd, out_blank);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int e;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 14'd16383;
        @(posedge clk); #1;
        in_data = 14'd0;
        wait_out(e);
        checks++;
        if (e !== 14 || out_bcd !== 20'h16383 || out_blank !== 5'b00000 || out_sign !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: edges=%0d bcd=%h blank=%b sign=%b want 14/16383/00000/0",
                     e, out_bcd, out_blank, out_sign);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_in_done: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_gap: out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
        end
        in_valid = 1'b0;
        wait_out(e);
        checks++;
        if (e !== 14 || out_bcd !== 20'h00000 || out_blank !== 5'b11110) begin
            failures++;
            $display("FAIL b2b_second: edges=%0d bcd=%h blank=%b want 14/00000/11110", e, out_bcd, out_blank);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int e;
        int bad;
        out_ready = 1'b0;
        send(14'd1234);
        wait_out(e);
        checks++;
        if (e !== 14 || out_bcd !== 20'h01234) begin
            failures++;
            $display("FAIL bp_result: edges=%0d bcd=%h want 14/01234", e, out_bcd);
        end
        in_valid = 1'b1;
        in_data  = 14'd77;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_bcd !== 20'h01234 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold: bad_cycles=%0d want 0 (last valid=%b bcd=%h in_ready=%b)",
                     bad, out_valid, out_bcd, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 20'h01234) begin
            failures++;
            $display("FAIL bp_release: valid=%b in_ready=%b bcd=%h want 0/1/01234", out_valid, in_ready, out_bcd);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int e;
        int seen;
        out_ready = 1'b0;
        send(14'd5555);
        repeat (7) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== 20'h0) begin
            failures++;
            $display("FAIL rst_mid_async: in_ready=%b valid=%b bcd=%h want 1/0/00000", in_ready, out_valid, out_bcd);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_mid_discard: non_idle_cycles=%0d want 0", seen);
        end
        send(14'd42);
        wait_out(e);
        checks++;
        if (e !== 14 || out_bcd !== 20'h00042 || out_blank !== 5'b11100) begin
            failures++;
            $display("FAIL rst_mid_next: edges=%0d bcd=%h blank=%b want 14/00042/11100", e, out_bcd, out_blank);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_signed;
        logic [7:0]  vin  [4];
        logic [11:0] vbcd [4];
        logic        vsgn [4];
        logic [2:0]  vblk [4];
        int e;
        vin[0] = 8'h80; vbcd[0] = 12'h128; vsgn[0] = 1'b1; vblk[0] = 3'b000;
        vin[1] = 8'hFF; vbcd[1] = 12'h001; vsgn[1] = 1'b1; vblk[1] = 3'b110;
        vin[2] = 8'h7F; vbcd[2] = 12'h127; vsgn[2] = 1'b0; vblk[2] = 3'b000;
        vin[3] = 8'hF6; vbcd[3] = 12'h010; vsgn[3] = 1'b1; vblk[3] = 3'b100;
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_convert(vin[i], e);
            checks++;
            if (e !== 8 || s_out_bcd !== vbcd[i] || s_out_sign !== vsgn[i] || s_out_blank !== vblk[i]) begin
                failures++;
                $display("FAIL signed_%h: edges=%0d bcd=%h sign=%b blank=%b want 8/%h/%b/%b",
                         vin[i], e, s_out_bcd, s_out_sign, s_out_blank, vbcd[i], vsgn[i], vblk[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sweep;
        int e;
        int v;
        logic [19:0] exp_bcd;
        out_ready = 1'b0;
        for (int i = 0; i < 1175; i++) begin
            if (i < 1024)       v = i;
            else if (i == 1024) v = 16383;
            else                v = int'($urandom_range(0, 16383));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(14'(v));
            wait_out(e);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            exp_bcd = model_bcd(v);
            checks++;
            if (e !== 14 || out_valid !== 1'b1 || out_bcd !== exp_bcd
                || out_blank !== model_blank(exp_bcd) || out_sign !== 1'b0) begin
                failures++;
                $display("FAIL sweep_%0d: edges=%0d valid=%b bcd=%h blank=%b sign=%b want 14/1/%h/%b/0",
                         v, e, out_valid, out_bcd, out_blank, out_sign, exp_bcd, model_blank(exp_bcd));
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_latency_9999;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        test_signed;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
